// File: rtl/fir_coef_writer_if.sv
// Byte-stream input and coefficient-bank write bus of the FIR coefficient loader.
interface fir_coef_writer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [31:0] coef_data;
  logic        commit;
  logic        busy;
  logic        err;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, coef_we, coef_addr, coef_data, commit, busy, err
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, coef_we, coef_addr, coef_data, commit, busy, err
  );
endinterface

// File: rtl/fir_coef_writer.sv
// Parses SYNC-framed coefficient bytes, writes each 32-bit tap to the shadow bank and
// commits the bank only when the frame's XOR checksum matches.
module fir_coef_writer #(
  parameter int unsigned NTAPS = 16,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input logic              clk,
  input logic              rst_n,
  fir_coef_writer_if.slave bus
);

  localparam logic [5:0] LastByte = 6'(4 * NTAPS - 1);

  typedef enum logic [1:0] {StIdle, StData, StCheck, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [23:0] asm_q, asm_d;
  logic        match_q, match_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        we_q, we_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        commit_q, commit_d;
  logic        err_q, err_d;
  logic        accept;

  assign accept = bus.byte_valid & ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xor_d    = xor_q;
    asm_d    = asm_q;
    match_d  = match_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    commit_d = 1'b0;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (accept && bus.byte_in == SYNC) begin
          state_d = StData;
          cnt_d   = '0;
          xor_d   = '0;
          err_d   = 1'b0;
        end
      end
      StData: begin
        if (accept) begin
          // LSB arrives first, so new bytes enter at the top of the assembler.
          asm_d = {bus.byte_in, asm_q[23:8]};
          xor_d = xor_q ^ bus.byte_in;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q[1:0] == 2'd3) begin
            we_d   = 1'b1;
            addr_d = cnt_q[5:2];
            data_d = {bus.byte_in, asm_q};
          end
          if (cnt_q == LastByte) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (accept) begin
          match_d = (bus.byte_in == xor_q);
          state_d = StDone;
        end
      end
      StDone: begin
        // Verdict is registered out of DONE so commit trails the last tap write by two cycles.
        state_d  = StIdle;
        commit_d = match_q;
        err_d    = err_q | ~match_q;
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d != StDone);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      xor_q    <= '0;
      asm_q    <= '0;
      match_q  <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xor_q    <= xor_d;
      asm_q    <= asm_d;
      match_q  <= match_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.coef_we    = we_q;
  assign bus.coef_addr  = addr_q;
  assign bus.coef_data  = data_q;
  assign bus.commit     = commit_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule
